// File: rtl/pll_mon_pkg.sv
// rtl/pll_mon_pkg.sv - shared FSM state type and default parameters for the PLL lock monitor
package pll_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_t;

   localparam int DEF_GATE_CYCLES  = 25000;
   localparam int DEF_EXP_MIN      = 5900;
   localparam int DEF_EXP_MAX      = 6100;
   localparam int DEF_LOCK_WINDOWS = 4;
   localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/meas_sync.sv
// rtl/meas_sync.sv - synchronizes the divided PLL clock into clkin and flags its rising edges
module meas_sync (
   input  logic clkin,
   input  logic rstn,
   input  logic meas_in,
   output logic meas_rise
);

   // sync_q[0..1] form the metastability chain, sync_q[2] is the edge-detect history stage
   logic [2:0] sync_q;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], meas_in};
      end
   end

   assign meas_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - counts PLL output edges per gate window and tracks lock/fault status
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
   parameter int EXP_MIN      = DEF_EXP_MIN,
   parameter int EXP_MAX      = DEF_EXP_MAX,
   parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clkin,
   input  logic             rstn,
   input  logic             meas_in,
   input  logic             enable,
   input  logic             clear_fault,
   output logic [CNT_W-1:0] freq_count,
   output logic             count_valid,
   output logic             locked,
   output logic             fault
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
   localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(EXP_MAX);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_WINDOWS);

   mon_state_t        state_q, state_d;
   logic [GATE_W-1:0] gate_q;
   logic [CNT_W-1:0]  edge_q;
   logic [CNT_W-1:0]  edge_total;
   logic [CNT_W-1:0]  freq_q;
   logic              valid_q;
   logic [GOOD_W-1:0] good_q, good_d, good_inc;
   logic              fault_q, fault_set;
   logic              meas_rise;
   logic              running;
   logic              gate_term;
   logic              window_good;

   meas_sync u_meas_sync (
      .clkin     (clkin),
      .rstn      (rstn),
      .meas_in   (meas_in),
      .meas_rise (meas_rise)
   );

   assign running   = enable && (state_q != ST_IDLE);
   assign gate_term = running && (gate_q == GATE_LAST);

   // Saturating so a wildly fast input never wraps back into the good range
   assign edge_total = (meas_rise && (edge_q != CNT_SAT)) ? edge_q + 1'b1 : edge_q;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         gate_q  <= '0;
         edge_q  <= '0;
         freq_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!running) begin
            gate_q <= '0;
            edge_q <= '0;
         end else if (gate_term) begin
            gate_q  <= '0;
            edge_q  <= '0;
            freq_q  <= edge_total;
            valid_q <= 1'b1;
         end else begin
            gate_q <= gate_q + 1'b1;
            edge_q <= edge_total;
         end
      end
   end

   assign window_good = (freq_q >= CNT_MIN) && (freq_q <= CNT_MAX);
   assign good_inc    = good_q + 1'b1;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         good_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         // A coincident loss event overrides a clear request
         if (fault_set) begin
            fault_q <= 1'b1;
         end else if (clear_fault) begin
            fault_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      fault_set = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
               good_d  = '0;
            end
            ST_ACQUIRE: begin
               if (valid_q) begin
                  if (window_good) begin
                     good_d = good_inc;
                     if (good_inc == GOOD_LOCK) begin
                        state_d = ST_LOCKED;
                     end
                  end else begin
                     good_d = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (valid_q && !window_good) begin
                  state_d   = ST_LOST;
                  fault_set = 1'b1;
               end
            end
            ST_LOST: begin
               state_d = ST_ACQUIRE;
               good_d  = '0;
            end
            default: begin
               state_d = ST_IDLE;
               good_d  = '0;
            end
         endcase
      end
   end

   assign freq_count  = freq_q;
   assign count_valid = valid_q;
   assign locked      = (state_q == ST_LOCKED);
   assign fault       = fault_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed scoreboard bench for pll_lock_monitor
module tb_pll_lock_monitor;

   typedef struct {
      int cnt;
      bit lck;
      bit flt;
   } exp_t;

   logic        clkin;
   logic        rstn;
   logic        meas_in;
   logic        enable;
   logic        clear_fault;
   logic [15:0] freq_count;
   logic        count_valid;
   logic        locked;
   logic        fault;

   int   checks;
   int   errors;
   exp_t exp_q[$];

   pll_lock_monitor #(
      .GATE_CYCLES  (100),
      .EXP_MIN      (24),
      .EXP_MAX      (26),
      .LOCK_WINDOWS (3),
      .CNT_W        (16)
   ) dut (
      .clkin       (clkin),
      .rstn        (rstn),
      .meas_in     (meas_in),
      .enable      (enable),
      .clear_fault (clear_fault),
      .freq_count  (freq_count),
      .count_valid (count_valid),
      .locked      (locked),
      .fault       (fault)
   );

   initial begin
      clkin = 1'b0;
      forever #20 clkin = ~clkin;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push(input int cnt, input bit lck, input bit flt);
      exp_t e;
      e.cnt = cnt;
      e.lck = lck;
      e.flt = flt;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; offset 0 is the negedge before the window's first gate cycle.
   // Pulses are one cycle high at offsets first + step*i for i < n.
   task automatic drive_window(input int n, input int step, input int first,
                               input int clr_off, input int len);
      for (int c = 0; c < len; c++) begin
         meas_in     = (c >= first && ((c - first) % step) == 0 && ((c - first) / step) < n) ? 1'b1 : 1'b0;
         clear_fault = (c == clr_off) ? 1'b1 : 1'b0;
         @(negedge clkin);
      end
      meas_in     = 1'b0;
      clear_fault = 1'b0;
   endtask

   task automatic win(input int n, input int step, input int first, input int clr_off,
                      input int cnt, input bit lck, input bit flt);
      push(cnt, lck, flt);
      drive_window(n, step, first, clr_off, 100);
   endtask

   // Scoreboard monitor: freq_count on each count_valid, locked/fault one cycle later
   initial begin
      exp_t cur;
      bit   pend;
      pend = 1'b0;
      forever begin
         @(negedge clkin);
         if (pend) begin
            check("locked_after_valid", {31'd0, locked}, {31'd0, cur.lck});
            check("fault_after_valid", {31'd0, fault}, {31'd0, cur.flt});
            pend = 1'b0;
         end
         if (count_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_count_valid", {31'd0, count_valid}, 32'd0);
            end else begin
               cur  = exp_q.pop_front();
               check("freq_count", {16'd0, freq_count}, cur.cnt);
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rstn        = 1'b0;
      meas_in     = 1'b0;
      enable      = 1'b0;
      clear_fault = 1'b0;

      @(negedge clkin);
      @(negedge clkin);
      check("rst_freq_count", {16'd0, freq_count}, 32'd0);
      check("rst_count_valid", {31'd0, count_valid}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      rstn = 1'b1;
      @(negedge clkin);
      @(negedge clkin);

      // Acquire: an edge every 4 cycles gives 25 per window
      enable = 1'b1;
      win(25, 4, 0, -1, 25, 1'b0, 1'b0);
      win(25, 4, 0, -1, 25, 1'b0, 1'b0);
      win(25, 4, 0, -1, 25, 1'b1, 1'b0);

      // Loss and re-lock
      win(0, 4, 0, -1, 0, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b1, 1'b1);

      // Clear alone mid-window
      win(25, 4, 0, 50, 25, 1'b1, 1'b0);

      // Range boundaries; the 27 window must reset the good-window count
      win(24, 2, 0, -1, 24, 1'b1, 1'b0);
      win(26, 2, 0, -1, 26, 1'b1, 1'b0);
      win(23, 2, 0, -1, 23, 1'b0, 1'b1);
      win(27, 2, 0, -1, 27, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b0, 1'b1);
      win(24, 2, 0, -1, 24, 1'b1, 1'b1);

      // Last edge lands on the terminal gate cycle; next window starts from zero
      win(24, 2, 52, 30, 24, 1'b1, 1'b0);
      win(25, 4, 0, -1, 25, 1'b1, 1'b0);

      // Loss with clear_fault in the same cycle: set wins
      win(0, 4, 0, -1, 0, 1'b0, 1'b1);
      win(25, 4, 0, 1, 25, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b0, 1'b1);
      win(25, 4, 0, -1, 25, 1'b1, 1'b1);

      // Enable dropped while locked
      drive_window(25, 4, 0, -1, 10);
      enable = 1'b0;
      @(negedge clkin);
      check("disable_locked", {31'd0, locked}, 32'd0);
      check("disable_fault_kept", {31'd0, fault}, 32'd1);
      @(negedge clkin);
      @(negedge clkin);
      check("idle_fault_kept", {31'd0, fault}, 32'd1);
      clear_fault = 1'b1;
      @(negedge clkin);
      clear_fault = 1'b0;
      check("clear_alone_fault", {31'd0, fault}, 32'd0);

      // Reset at gate count 50
      enable = 1'b1;
      drive_window(25, 4, 0, -1, 50);
      rstn   = 1'b0;
      enable = 1'b0;
      #1;
      check("midrst_freq_count", {16'd0, freq_count}, 32'd0);
      check("midrst_count_valid", {31'd0, count_valid}, 32'd0);
      check("midrst_locked", {31'd0, locked}, 32'd0);
      check("midrst_fault", {31'd0, fault}, 32'd0);
      @(negedge clkin);
      rstn = 1'b1;
      @(negedge clkin);
      check("postrst_count_valid", {31'd0, count_valid}, 32'd0);
      enable = 1'b1;
      win(25, 4, 0, -1, 25, 1'b0, 1'b0);
      drive_window(0, 4, 0, -1, 4);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter GATE_CYCLES, default 25000, sets the measurement window length in clkin cycles (1 ms at 25 MHz).
REQ-002 Parameter EXP_MIN, default 5900, is the minimum acceptable rising-edge count per window.
REQ-003 Parameter EXP_MAX, default 6100, is the maximum acceptable rising-edge count per window.
REQ-004 Parameter LOCK_WINDOWS, default 4, is the number of consecutive in-range windows required before lock.
REQ-005 Parameter CNT_W, default 16, is the edge-count width; EXP_MAX SHALL be < 2**CNT_W-1.
REQ-006 clkin  input  1  sole clock, the 25 MHz board reference; the block SHALL use one clock.
REQ-007 rstn  input  1  reset; SHALL be asynchronous and active-low.
REQ-008 meas_in  input  1  divided PLL output (CLKOUTD-class), asynchronous to clkin.
REQ-009 enable  input  1  monitoring enable.
REQ-010 clear_fault  input  1  single-cycle clear of the sticky fault.
REQ-011 freq_count  output  CNT_W  edge count of the last completed window.
REQ-012 count_valid  output  1  one-cycle pulse when freq_count updates.
REQ-013 locked  output  1  PLL output judged in range and stable.
REQ-014 fault  output  1  sticky flag set on loss of lock.

Function
REQ-015 meas_in SHALL pass a 2-FF synchronizer plus a third stage; a rising edge is sync2=1 and sync3=0.
REQ-016 The gate counter SHALL run 0..GATE_CYCLES-1 while enable=1, then wrap to 0.
REQ-017 The edge counter SHALL increment on each detected edge and saturate at all-ones.
REQ-018 At gate terminal count, freq_count SHALL load the edge total, including any edge in that cycle, and count_valid SHALL pulse the same cycle.
REQ-019 After the terminal count, the edge counter SHALL restart at 0 for the next window.
REQ-020 A window is good when EXP_MIN <= freq_count <= EXP_MAX, inclusive.
REQ-021 FSM states: IDLE, ACQUIRE, LOCKED, LOST.
REQ-022 IDLE SHALL go to ACQUIRE when enable=1, clearing the gate, edge and good-window counters.
REQ-023 In ACQUIRE, a good window SHALL increment good_cnt and a bad window SHALL reset it to 0.
REQ-024 ACQUIRE SHALL go to LOCKED when good_cnt reaches LOCK_WINDOWS.
REQ-025 locked SHALL assert the cycle after the count_valid of the LOCK_WINDOWS-th consecutive good window.
REQ-026 In LOCKED, a bad window SHALL move the FSM to LOST, set fault, and deassert locked the cycle after count_valid.
REQ-027 LOST SHALL last exactly one cycle, then go to ACQUIRE with good_cnt=0.
REQ-028 enable=0 in any state SHALL force IDLE next cycle: locked=0, counters cleared, fault retained.
REQ-029 clear_fault SHALL clear fault; if it coincides with a fault-setting event, set SHALL win.
REQ-030 locked SHALL be 1 only in LOCKED.

Reset
REQ-031 On rstn=0: FSM=IDLE; all counters and synchronizer stages 0; freq_count=0; count_valid=0; locked=0; fault=0.
REQ-032 Reset mid-window SHALL discard the partial count and produce no count_valid pulse.

Structure
REQ-033 Package pll_mon_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 Synchronizer and edge detect SHALL be sub-module meas_sync; all other logic SHALL be in pll_lock_monitor.

Verification
(All scenarios use GATE_CYCLES=100, EXP_MIN=24, EXP_MAX=26, LOCK_WINDOWS=3.)
REQ-035 Lock acquire: meas_in edge every 4 clkin -> freq_count=25 each window; locked=1 one cycle after the 3rd count_valid.
REQ-036 Loss: after lock, meas_in stopped -> next freq_count=0; fault=1 and locked=0 the cycle after that count_valid; re-lock after 3 good windows.
REQ-037 Boundary: 24 and 26 edges -> good; 23 and 27 edges -> bad, good_cnt=0.
REQ-038 Edge on terminal cycle: window with 24 edges, the last on cycle 99 -> freq_count=24, next window starts at 0.
REQ-039 Simultaneous: clear_fault asserted in the same cycle a loss sets fault -> fault=1; clear_fault alone later -> fault=0.
REQ-040 Reset/enable mid-window: rstn pulsed at gate count 50 -> all outputs 0, no count_valid; enable dropped while locked -> locked=0 next cycle, fault unchanged.
